// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared types and constants for the PS/2 keyboard receiver:
//   - receive FSM state encoding
//   - register offsets relative to BASE_ADDR
//   - bit positions inside the status word
//   - odd-parity helper used when a frame completes
// ---------------------------------------------------------------------------
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } ps2_state_e;

   localparam logic [31:0] DATA_OFS = 32'd0;
   localparam logic [31:0] STAT_OFS = 32'd4;

   // Status word layout: {25'b0, overflow, parity_err, frame_err, count[2:0], not_empty}
   localparam int STAT_NOT_EMPTY  = 0;
   localparam int STAT_COUNT_LO   = 1;
   localparam int STAT_FRAME_ERR  = 4;
   localparam int STAT_PARITY_ERR = 5;
   localparam int STAT_OVERFLOW   = 6;

   // True when the 8 data bits plus the parity bit hold an odd number of ones.
   function automatic logic odd_parity_ok(input logic [7:0] code, input logic par);
      return ^{code, par};
   endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// ---------------------------------------------------------------------------
// ps2_sync_fifo
// Small synchronous show-ahead FIFO: dout always presents the head entry, and
// pop simply advances past it. DEPTH must be a power of two (>= 2) so the
// pointers wrap naturally.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   push, din    write request and data (ignored when full unless popping)
//   pop          advance past the head (ignored when empty)
//   dout         head entry
//   count        number of stored entries (0..DEPTH)
//   full, empty  occupancy flags
// ---------------------------------------------------------------------------
module ps2_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;
   logic             do_push_s;
   logic             do_pop_s;

   assign empty = (count_r == {CW{1'b0}});
   assign full  = (count_r == CW'(DEPTH));
   assign count = count_r;
   assign dout  = mem_r[rd_ptr_r];

   // A full FIFO still accepts a write when the head leaves in the same cycle.
   assign do_pop_s  = pop & ~empty;
   assign do_push_s = push & (~full | do_pop_s);

   // Storage array and pointers.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
      end else begin
         if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
            wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1'b1);
         end
      end
   end

   // Occupancy counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_r <= {CW{1'b0}};
      end else begin
         count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
      end
   end

endmodule

// File: rtl/ps2_rx_mmio.sv
// ---------------------------------------------------------------------------
// ps2_rx_mmio
// PS/2 keyboard receiver with a polled memory-mapped read port.
// The PS/2 clock/data pair is synchronised, the clock is de-glitched, each
// 11-bit frame (start, 8 data LSB-first, odd parity, stop) is deframed and
// good scan codes are queued in a small FIFO.
// Ports:
//   clock_50   system clock
//   reset      synchronous active-high reset
//   ps2_clk    asynchronous PS/2 clock from the keyboard
//   ps2_data   asynchronous PS/2 data from the keyboard
//   DataAdr    core byte address
//   ReadEn     one-cycle read strobe
//   ReadData   registered read data (BASE_ADDR: code, BASE_ADDR+4: status)
//   irq        high while the FIFO holds at least one code
// ---------------------------------------------------------------------------
module ps2_rx_mmio
   import ps2_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0100,
   parameter int          FIFO_DEPTH = 4,
   parameter int          FILTER     = 8,
   parameter int          TIMEOUT    = 50000
) (
   input  logic        clock_50,
   input  logic        reset,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   input  logic [31:0] DataAdr,
   input  logic        ReadEn,
   output logic [31:0] ReadData,
   output logic        irq
);

   localparam int FCW = $clog2(FILTER + 1);
   localparam int TCW = $clog2(TIMEOUT + 1);
   localparam int CW  = $clog2(FIFO_DEPTH) + 1;

   localparam logic [FCW-1:0] FILTER_LAST = FCW'(FILTER - 1);
   localparam logic [TCW-1:0] TMO_LAST    = TCW'(TIMEOUT - 1);
   localparam logic [31:0]    DATA_ADDR   = BASE_ADDR + DATA_OFS;
   localparam logic [31:0]    STAT_ADDR   = BASE_ADDR + STAT_OFS;

   // Synchroniser and filter
   logic           clk_meta_r;
   logic           clk_sync_r;
   logic           data_meta_r;
   logic           data_sync_r;
   logic           filt_level_r;
   logic [FCW-1:0] filt_cnt_r;
   logic           fall_r;

   // Receive FSM
   ps2_state_e     state_r;
   ps2_state_e     state_nxt;
   logic [2:0]     bit_idx_r;
   logic [2:0]     bit_idx_nxt;
   logic [7:0]     shift_r;
   logic [7:0]     shift_nxt;
   logic           par_r;
   logic           par_nxt;
   logic [TCW-1:0] tmo_cnt_r;
   logic [TCW-1:0] tmo_nxt;
   logic           tmo_hit_s;
   logic           push_s;
   logic           frame_set_s;
   logic           parity_set_s;

   // FIFO and register interface
   logic [7:0]     fifo_dout_s;
   logic [CW-1:0]  fifo_count_s;
   logic [2:0]     count3_s;
   logic           fifo_full_s;
   logic           fifo_empty_s;
   logic           data_hit_s;
   logic           stat_hit_s;
   logic           pop_s;
   logic           overflow_set_s;
   logic           overflow_r;
   logic           parity_err_r;
   logic           frame_err_r;
   logic [31:0]    stat_word_s;
   logic [31:0]    rd_nxt_s;

   // Two-flop synchronisers; idle PS/2 lines are high, so reset to 1.
   always_ff @(posedge clock_50) begin
      if (reset) begin
         clk_meta_r  <= 1'b1;
         clk_sync_r  <= 1'b1;
         data_meta_r <= 1'b1;
         data_sync_r <= 1'b1;
      end else begin
         clk_meta_r  <= ps2_clk;
         clk_sync_r  <= clk_meta_r;
         data_meta_r <= ps2_data;
         data_sync_r <= data_meta_r;
      end
   end

   // Clock de-glitch: the filtered level follows only after FILTER stable cycles;
   // a 1->0 acceptance raises a one-cycle fall pulse.
   always_ff @(posedge clock_50) begin
      if (reset) begin
         filt_level_r <= 1'b1;
         filt_cnt_r   <= {FCW{1'b0}};
         fall_r       <= 1'b0;
      end else if (clk_sync_r != filt_level_r) begin
         if (filt_cnt_r == FILTER_LAST) begin
            filt_level_r <= clk_sync_r;
            filt_cnt_r   <= {FCW{1'b0}};
            fall_r       <= ~clk_sync_r;
         end else begin
            filt_cnt_r   <= filt_cnt_r + FCW'(1'b1);
            fall_r       <= 1'b0;
         end
      end else begin
         filt_cnt_r <= {FCW{1'b0}};
         fall_r     <= 1'b0;
      end
   end

   // Inter-edge timeout fires only inside a frame and without a fall this cycle.
   assign tmo_hit_s = (state_r != IDLE) && !fall_r && (tmo_cnt_r == TMO_LAST);

   // Timeout counter next value.
   always_comb begin
      tmo_nxt = tmo_cnt_r;
      if ((state_r == IDLE) || fall_r || tmo_hit_s) begin
         tmo_nxt = {TCW{1'b0}};
      end else begin
         tmo_nxt = tmo_cnt_r + TCW'(1'b1);
      end
   end

   // Receive FSM next state and frame-completion events.
   always_comb begin
      state_nxt    = state_r;
      bit_idx_nxt  = bit_idx_r;
      shift_nxt    = shift_r;
      par_nxt      = par_r;
      push_s       = 1'b0;
      frame_set_s  = 1'b0;
      parity_set_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (fall_r && !data_sync_r) begin
               state_nxt   = DATA;
               bit_idx_nxt = 3'd0;
            end else begin
               state_nxt = IDLE;
            end
         end
         DATA: begin
            if (fall_r) begin
               shift_nxt = {data_sync_r, shift_r[7:1]};
               if (bit_idx_r == 3'd7) begin
                  state_nxt   = PARITY;
                  bit_idx_nxt = 3'd0;
               end else begin
                  state_nxt   = DATA;
                  bit_idx_nxt = bit_idx_r + 3'd1;
               end
            end else if (tmo_hit_s) begin
               state_nxt   = IDLE;
               frame_set_s = 1'b1;
            end else begin
               state_nxt = DATA;
            end
         end
         PARITY: begin
            if (fall_r) begin
               par_nxt   = data_sync_r;
               state_nxt = STOP;
            end else if (tmo_hit_s) begin
               state_nxt   = IDLE;
               frame_set_s = 1'b1;
            end else begin
               state_nxt = PARITY;
            end
         end
         STOP: begin
            if (fall_r) begin
               state_nxt = IDLE;
               if (!data_sync_r) begin
                  frame_set_s = 1'b1;
               end else if (odd_parity_ok(shift_r, par_r)) begin
                  push_s = 1'b1;
               end else begin
                  parity_set_s = 1'b1;
               end
            end else if (tmo_hit_s) begin
               state_nxt   = IDLE;
               frame_set_s = 1'b1;
            end else begin
               state_nxt = STOP;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Receive FSM state register.
   always_ff @(posedge clock_50) begin
      if (reset) begin
         state_r   <= IDLE;
         bit_idx_r <= 3'd0;
         shift_r   <= 8'h00;
         par_r     <= 1'b0;
         tmo_cnt_r <= {TCW{1'b0}};
      end else begin
         state_r   <= state_nxt;
         bit_idx_r <= bit_idx_nxt;
         shift_r   <= shift_nxt;
         par_r     <= par_nxt;
         tmo_cnt_r <= tmo_nxt;
      end
   end

   assign data_hit_s = ReadEn && (DataAdr == DATA_ADDR);
   assign stat_hit_s = ReadEn && (DataAdr == STAT_ADDR);
   assign pop_s      = data_hit_s && !fifo_empty_s;
   // A pop in the same cycle makes room, so the push is not an overflow.
   assign overflow_set_s = push_s && fifo_full_s && !pop_s;

   ps2_sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clock_50),
      .reset (reset),
      .push  (push_s),
      .pop   (pop_s),
      .din   (shift_r),
      .dout  (fifo_dout_s),
      .count (fifo_count_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s)
   );

   // Sticky error flags: cleared by a status read unless re-set in that cycle.
   always_ff @(posedge clock_50) begin
      if (reset) begin
         overflow_r   <= 1'b0;
         parity_err_r <= 1'b0;
         frame_err_r  <= 1'b0;
      end else begin
         overflow_r   <= overflow_set_s | (overflow_r   & ~stat_hit_s);
         parity_err_r <= parity_set_s   | (parity_err_r & ~stat_hit_s);
         frame_err_r  <= frame_set_s    | (frame_err_r  & ~stat_hit_s);
      end
   end

   assign count3_s = 3'(fifo_count_s);

   // Status word assembly.
   always_comb begin
      stat_word_s                          = 32'h0000_0000;
      stat_word_s[STAT_NOT_EMPTY]          = ~fifo_empty_s;
      stat_word_s[STAT_COUNT_LO +: 3]      = count3_s;
      stat_word_s[STAT_FRAME_ERR]          = frame_err_r;
      stat_word_s[STAT_PARITY_ERR]         = parity_err_r;
      stat_word_s[STAT_OVERFLOW]           = overflow_r;
   end

   // Read multiplexer; ReadData holds when no read is strobed.
   always_comb begin
      rd_nxt_s = ReadData;
      if (data_hit_s) begin
         if (fifo_empty_s) begin
            rd_nxt_s = 32'h0000_0000;
         end else begin
            rd_nxt_s = {23'd0, 1'b1, fifo_dout_s};
         end
      end else if (stat_hit_s) begin
         rd_nxt_s = stat_word_s;
      end else if (ReadEn) begin
         rd_nxt_s = 32'h0000_0000;
      end else begin
         rd_nxt_s = ReadData;
      end
   end

   // Registered read data and interrupt.
   always_ff @(posedge clock_50) begin
      if (reset) begin
         ReadData <= 32'h0000_0000;
         irq      <= 1'b0;
      end else begin
         ReadData <= rd_nxt_s;
         irq      <= ~fifo_empty_s;
      end
   end

endmodule
